// File: rtl/voltmeter_pkg.sv
// Shared definitions for the voltmeter SPI readout path: word width, FSM states
// and the bit layout of the debug status word.
package voltmeter_pkg;

    localparam int unsigned SPI_WORD_W = 32;
    localparam int unsigned SPI_BIT_CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        HOLD     = 3'd4,
        GAP      = 3'd5
    } spi_state_e;

    // Debug status word layout
    localparam int unsigned STAT_W          = 16;
    localparam int unsigned STAT_BUSY_BIT   = 0;
    localparam int unsigned STAT_DONE_BIT   = 1;
    localparam int unsigned STAT_CS_BIT     = 2;
    localparam int unsigned STAT_STATE_LSB  = 4;
    localparam int unsigned STAT_BITCNT_LSB = 8;

    function automatic logic [STAT_W-1:0] pack_status(
        input logic                     busy,
        input logic                     done,
        input logic                     cs,
        input spi_state_e               st,
        input logic [SPI_BIT_CNT_W-1:0] bit_cnt
    );
        logic [STAT_W-1:0] s;
        s                                   = '0;
        s[STAT_BUSY_BIT]                    = busy;
        s[STAT_DONE_BIT]                    = done;
        s[STAT_CS_BIT]                      = cs;
        s[STAT_STATE_LSB +: 3]              = st;
        s[STAT_BITCNT_LSB +: SPI_BIT_CNT_W] = bit_cnt;
        return s;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Phase-length divider: tick_o marks the last clk_i cycle of every CLK_DIV-cycle
// phase. reload_i restarts the phase so every FSM state gets a full H cycles.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic reload_i,
    output logic tick_o
);

    logic [7:0] cnt_q;

    assign tick_o = (cnt_q == 8'(CLK_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (reload_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/spi_readout_master.sv
// Mode-0 SPI master that shifts one WORD_W-bit word out on MOSI while capturing
// the slave's reply from MISO, MSB first, then presents it on rx_word_o.
module spi_readout_master
    import voltmeter_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned WORD_W  = SPI_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WORD_W-1:0] tx_word_i,
    output logic [WORD_W-1:0] rx_word_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              spi_sclk_o,
    output logic              spi_cs_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i
);

    localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = SPI_BIT_CNT_W'(WORD_W);

    spi_state_e                 state_q, state_d;
    logic                       tick;
    logic                       reload;
    logic                       enter_hi;
    logic                       enter_lo;
    logic                       cs_active;
    logic [WORD_W-1:0]          tx_sr;
    logic [WORD_W-1:0]          rx_sr;
    logic [SPI_BIT_CNT_W-1:0]   bit_cnt;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .reload_i (reload),
        .tick_o   (tick)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start_i) state_d = SETUP;
            SETUP:    if (tick)    state_d = SHIFT_HI;
            SHIFT_HI: if (tick)    state_d = SHIFT_LO;
            SHIFT_LO: if (tick)    state_d = (bit_cnt == LAST_BIT) ? HOLD : SHIFT_HI;
            HOLD:     if (tick)    state_d = GAP;
            GAP:      if (tick)    state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    assign reload   = (state_d != state_q);
    assign enter_hi = (state_d == SHIFT_HI) && (state_q != SHIFT_HI);
    assign enter_lo = (state_d == SHIFT_LO) && (state_q != SHIFT_LO);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            rx_word_o <= '0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state_q == IDLE && start_i) begin
                tx_sr   <= tx_word_i;
                bit_cnt <= '0;
            end
            if (enter_hi) begin
                rx_sr   <= {rx_sr[WORD_W-2:0], spi_miso_i};
                bit_cnt <= bit_cnt + 1'b1;
            end
            // The last bit stays on MOSI through HOLD.
            if (enter_lo && bit_cnt != LAST_BIT) begin
                tx_sr <= {tx_sr[WORD_W-2:0], 1'b0};
            end
            if (state_q == HOLD && tick) begin
                rx_word_o <= rx_sr;
                done_o    <= 1'b1;
            end
        end
    end

    // CS drops combinationally in the accepting IDLE cycle, so back-to-back
    // transactions only see CS high for the GAP phase.
    assign cs_active  = (state_q == IDLE) ? start_i : (state_q != GAP);
    assign spi_cs_o   = ~cs_active;
    assign spi_sclk_o = (state_q == SHIFT_HI);
    assign spi_mosi_o = cs_active &
                        ((state_q == IDLE) ? tx_word_i[WORD_W-1] : tx_sr[WORD_W-1]);
    assign busy_o     = (state_q != IDLE);

endmodule

// File: doc/spi_readout_master.md
SPI_READOUT_MASTER -- requirements
Module: spi_readout_master

Interface
REQ-001 Parameter CLK_DIV, default 2: SCLK half-period in clk_i cycles (H); legal range 1..255.
REQ-002 Parameter WORD_W, default 32: bits per transaction.
REQ-003 clk_i  in  1  single system clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 start_i  in  1  request transaction; sampled only in IDLE.
REQ-006 tx_word_i  in  WORD_W  word to shift out; captured when start is accepted.
REQ-007 rx_word_o  out  WORD_W  last complete received word; held until the next done_o.
REQ-008 busy_o  out  1  high from the cycle after acceptance through the end of GAP.
REQ-009 done_o  out  1  one-cycle pulse when rx_word_o updates.
REQ-010 spi_sclk_o  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-011 spi_cs_o  out  1  chip select, active-low.
REQ-012 spi_mosi_o  out  1  master data out, MSB first.
REQ-013 spi_miso_i  in  1  slave data in; the bench drives it synchronous to clk_i.

Function
REQ-014 States SHALL be IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP.
REQ-015 IDLE with start_i=1 SHALL capture tx_word_i into the shift register, drive cs low, drive mosi=tx_word_i[WORD_W-1], and enter SETUP on the next cycle.
REQ-016 SETUP SHALL last H cycles with sclk low, then enter SHIFT_HI.
REQ-017 Entering SHIFT_HI SHALL raise sclk; on that same edge spi_miso_i is shifted into the receive register LSB; SHIFT_HI lasts H cycles.
REQ-018 Entering SHIFT_LO SHALL lower sclk; on that same edge mosi advances to the next bit, except after the last bit; SHIFT_LO lasts H cycles.
REQ-019 The bit counter (6 bits) SHALL count rising edges; after the WORD_W-th SHIFT_LO the FSM enters HOLD, otherwise SHIFT_HI.
REQ-020 HOLD SHALL last H cycles with cs low and sclk low.
REQ-021 On leaving HOLD: cs high, rx_word_o loaded, done_o pulsed, enter GAP.
REQ-022 GAP SHALL last H cycles with cs high, then return to IDLE.
REQ-023 Acceptance to done_o SHALL be (2*WORD_W+2)*H cycles; for H=2 and WORD_W=32 that is 132 cycles.
REQ-024 start_i SHALL be ignored outside IDLE, with no queuing; if start_i is held high, the next transaction begins on the first IDLE cycle.
REQ-025 mosi SHALL be 0 and sclk 0 whenever cs is high.
REQ-026 The divider counter SHALL reload on every state change; with H=1, each state lasts exactly one cycle.

Reset
REQ-027 rst_i=1 SHALL on the next edge force IDLE: cs=1, sclk=0, mosi=0, busy_o=0, done_o=0, rx_word_o=0, counters=0, including mid-transaction.
REQ-028 A transaction aborted by reset SHALL NOT pulse done_o and SHALL NOT update rx_word_o.

Structure
REQ-029 Shared package voltmeter_pkg SHALL hold SPI_WORD_W=32, the state enumeration, and the debug bit-field positions of the status word.
REQ-030 One sub-module spi_sclk_gen SHALL provide the H-cycle tick, reloadable by the FSM; all other logic SHALL be in spi_readout_master.

Verification
REQ-031 H=2, tx=0xA5A50F0F, miso looped to mosi -> rx_word_o=0xA5A50F0F, done_o exactly 132 cycles after acceptance, 32 sclk rising edges.
REQ-032 Mode-0 slave model returns 0xDEADBEEF, tx=0x80000001 -> rx_word_o=0xDEADBEEF; slave captured 0x80000001.
REQ-033 start_i pulsed at cycle 40 of an active transaction -> ignored, exactly one done_o; start_i held high -> cs high for exactly 2 cycles between transactions.
REQ-034 rst_i asserted at bit 17 -> next cycle cs=1, sclk=0, busy_o=0; no done_o; rx_word_o=0.
REQ-035 CLK_DIV=1, tx=0xFFFF0000 loopback -> rx_word_o=0xFFFF0000, done_o 66 cycles after acceptance.
